// File: rtl/cp0_irq_unit.sv
// CP0 subset for exception/interrupt handling: Count/Compare timer, Status,
// Cause, EPC, read-only ID registers, and a one-cycle pipeline redirect on events.
module cp0_irq_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_HW_IRQ = 6,
   parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(32'h0000_0180)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic [NUM_HW_IRQ-1:0] hw_irq,
   input  logic                  wr_en,
   input  logic [4:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [4:0]            rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  exc_valid,
   input  logic [4:0]            exc_code,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  in_delay_slot,
   input  logic                  eret,
   output logic                  flush,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  irq_pending
);

   localparam logic [4:0] ADDR_COUNT   = 5'd9;
   localparam logic [4:0] ADDR_COMPARE = 5'd11;
   localparam logic [4:0] ADDR_STATUS  = 5'd12;
   localparam logic [4:0] ADDR_CAUSE   = 5'd13;
   localparam logic [4:0] ADDR_EPC     = 5'd14;
   localparam logic [4:0] ADDR_PRID    = 5'd15;
   localparam logic [4:0] ADDR_CONFIG  = 5'd16;

   logic [DATA_WIDTH-1:0] count_reg, count_next;
   logic [DATA_WIDTH-1:0] compare_reg, compare_next;
   logic                  timer_flag_reg, timer_flag_next;
   logic [7:0]            im_reg, im_next;
   logic                  exl_reg, exl_next;
   logic                  ie_reg, ie_next;
   logic                  bd_reg, bd_next;
   logic [1:0]            sw_ip_reg, sw_ip_next;
   logic [4:0]            exc_code_reg, exc_code_next;
   logic [ADDR_WIDTH-1:0] epc_reg, epc_next;
   logic [NUM_HW_IRQ-1:0] sync1_reg, sync2_reg;
   logic                  flush_reg;
   logic [ADDR_WIDTH-1:0] redirect_pc_reg;

   logic [4:0]            hw_ip;
   logic                  hw_ip7;
   logic [7:0]            ip;
   logic                  wr_ok, take_irq, take_exc, take_eret, take_trap;
   logic [DATA_WIDTH-1:0] status_word, cause_word;

   // Synchronised lines 0..4 land on IP[2..6]; line 5 shares IP[7] with the timer.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_hw_ip
         if (gi < NUM_HW_IRQ) begin : g_used
            assign hw_ip[gi] = sync2_reg[gi];
         end else begin : g_unused
            assign hw_ip[gi] = 1'b0;
         end
      end
      if (NUM_HW_IRQ >= 6) begin : g_ip7_hw
         assign hw_ip7 = sync2_reg[5];
      end else begin : g_ip7_none
         assign hw_ip7 = 1'b0;
      end
   endgenerate

   assign ip          = {timer_flag_reg | hw_ip7, hw_ip, sw_ip_reg};
   assign irq_pending = ie_reg & ~exl_reg & |(ip & im_reg);

   assign wr_ok     = ~stall & wr_en;
   assign take_irq  = ~stall & irq_pending;
   assign take_exc  = ~stall & ~take_irq & exc_valid;
   assign take_eret = ~stall & ~take_irq & ~exc_valid & eret;
   assign take_trap = take_irq | take_exc;

   always_comb begin
      count_next      = count_reg + DATA_WIDTH'(1);
      compare_next    = compare_reg;
      timer_flag_next = timer_flag_reg;
      im_next         = im_reg;
      exl_next        = exl_reg;
      ie_next         = ie_reg;
      bd_next         = bd_reg;
      sw_ip_next      = sw_ip_reg;
      exc_code_next   = exc_code_reg;
      epc_next        = epc_reg;

      if (wr_ok && wr_addr == ADDR_COUNT)
         count_next = wr_data;

      // A Compare write clears the flag even if the counter matches this cycle.
      if (wr_ok && wr_addr == ADDR_COMPARE) begin
         compare_next    = wr_data;
         timer_flag_next = 1'b0;
      end else if (count_next == compare_reg && compare_reg != '0) begin
         timer_flag_next = 1'b1;
      end

      if (wr_ok && wr_addr == ADDR_STATUS) begin
         im_next  = wr_data[15:8];
         exl_next = wr_data[1];
         ie_next  = wr_data[0];
      end
      if (wr_ok && wr_addr == ADDR_CAUSE)
         sw_ip_next = wr_data[9:8];
      if (wr_ok && wr_addr == ADDR_EPC && !take_trap)
         epc_next = ADDR_WIDTH'(wr_data);

      // Events override the same-cycle software write on EPC/BD/ExcCode/EXL.
      if (take_trap) begin
         exc_code_next = take_irq ? 5'd0 : exc_code;
         if (!exl_reg) begin
            epc_next = in_delay_slot ? pc - ADDR_WIDTH'(4) : pc;
            bd_next  = in_delay_slot;
            exl_next = 1'b1;
         end
      end else if (take_eret) begin
         exl_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg       <= '0;
         compare_reg     <= '0;
         timer_flag_reg  <= 1'b0;
         im_reg          <= '0;
         exl_reg         <= 1'b0;
         ie_reg          <= 1'b0;
         bd_reg          <= 1'b0;
         sw_ip_reg       <= '0;
         exc_code_reg    <= '0;
         epc_reg         <= '0;
         sync1_reg       <= '0;
         sync2_reg       <= '0;
         flush_reg       <= 1'b0;
         redirect_pc_reg <= '0;
      end else begin
         count_reg      <= count_next;
         compare_reg    <= compare_next;
         timer_flag_reg <= timer_flag_next;
         im_reg         <= im_next;
         exl_reg        <= exl_next;
         ie_reg         <= ie_next;
         bd_reg         <= bd_next;
         sw_ip_reg      <= sw_ip_next;
         exc_code_reg   <= exc_code_next;
         epc_reg        <= epc_next;
         sync1_reg      <= hw_irq;
         sync2_reg      <= sync1_reg;
         flush_reg      <= take_trap | take_eret;
         if (take_trap)
            redirect_pc_reg <= EXC_VECTOR;
         else if (take_eret)
            redirect_pc_reg <= epc_reg;
      end
   end

   assign flush       = flush_reg;
   assign redirect_pc = redirect_pc_reg;

   always_comb begin
      status_word        = '0;
      status_word[15:8]  = im_reg;
      status_word[1]     = exl_reg;
      status_word[0]     = ie_reg;
      cause_word                 = '0;
      cause_word[DATA_WIDTH-1]   = bd_reg;
      cause_word[15:8]           = ip;
      cause_word[6:2]            = exc_code_reg;
   end

   // Reads see register outputs, so a same-cycle write is not yet visible.
   always_comb begin
      rd_data = '0;
      case (rd_addr)
         ADDR_COUNT:   rd_data = count_reg;
         ADDR_COMPARE: rd_data = compare_reg;
         ADDR_STATUS:  rd_data = status_word;
         ADDR_CAUSE:   rd_data = cause_word;
         ADDR_EPC:     rd_data = DATA_WIDTH'(epc_reg);
         ADDR_PRID:    rd_data = '0;
         ADDR_CONFIG:  rd_data = DATA_WIDTH'(32'h0000_8000);
         default:      rd_data = '0;
      endcase
   end

endmodule
